// File: rtl/ddr3_ca_lane_ctrl.sv
// ddr3_ca_lane_ctrl: DDR3 address/command lane data path with per-lane delay-line tap controller.
// Pulse outputs are registered and appear the cycle after the FSM decides to issue them.
module ddr3_ca_lane_ctrl #(
   parameter int LANES      = 15,
   parameter int RATIO      = 4,
   parameter int TAP_W      = 8,
   parameter int MAX_TAP    = 127,
   parameter int SETTLE_CYC = 3,
   parameter int PIPE       = 1,
   localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                     FAB_CLK,
   input  logic                     TX_SYNC_RST,
   input  logic [LANES*RATIO-1:0]   CA_DATA,
   input  logic [RATIO-1:0]         CA_OE,
   output logic [LANES*RATIO-1:0]   TX_DATA,
   output logic [LANES*RATIO-1:0]   OE_DATA,
   input  logic                     DL_REQ_VALID,
   output logic                     DL_REQ_READY,
   input  logic [LW-1:0]            DL_REQ_LANE,
   input  logic [TAP_W-1:0]         DL_REQ_TAP,
   input  logic                     DL_REQ_LOAD,
   output logic [LANES-1:0]         DELAY_LINE_MOVE,
   output logic [LANES-1:0]         DELAY_LINE_DIRECTION,
   output logic [LANES-1:0]         DELAY_LINE_LOAD,
   input  logic [LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
   output logic                     DL_DONE,
   output logic                     DL_ERR,
   output logic [TAP_W-1:0]         DL_CUR_TAP
);
   localparam int DW = LANES * RATIO;
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [TAP_W-1:0] MAX_T = TAP_W'(MAX_TAP);
   localparam logic [LW:0] LANES_V = (LW+1)'(LANES);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_MOVE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [LW-1:0]      lane_q, lane_d;
   logic [TAP_W-1:0]   tgt_q, tgt_d, cur_q, cur_d;
   logic               bad_q, bad_d, err_q, err_d, done_q, done_d, rdy_q, rdy_d;
   logic [LANES-1:0]   move_q, move_d, load_q, load_d, dir_q, dir_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [TAP_W-1:0]   tap_q [LANES];
   logic [TAP_W-1:0]   tap_d [LANES];
   logic [DW-1:0]      tx_q [PIPE];
   logic [DW-1:0]      tx_d [PIPE];
   logic [DW-1:0]      oe_q [PIPE];
   logic [DW-1:0]      oe_d [PIPE];

   always_comb begin
      tx_d[0] = CA_DATA;
      oe_d[0] = {LANES{CA_OE}};
      for (int i = 1; i < PIPE; i++) begin
         tx_d[i] = tx_q[i-1];
         oe_d[i] = oe_q[i-1];
      end
   end

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      tgt_d   = tgt_q;
      bad_d   = bad_q;
      err_d   = err_q;
      done_d  = 1'b0;
      move_d  = '0;
      load_d  = '0;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      tap_d   = tap_q;
      case (state_q)
         S_IDLE: if (DL_REQ_VALID && rdy_q) begin
            lane_d  = DL_REQ_LANE;
            tgt_d   = DL_REQ_TAP;
            bad_d   = (DL_REQ_TAP > MAX_T) || ({1'b0, DL_REQ_LANE} >= LANES_V);
            err_d   = bad_d;
            // an illegal request still passes through MOVE so its DONE lands two cycles out
            state_d = (!bad_d && DL_REQ_LOAD) ? S_LOAD : S_MOVE;
         end
         S_LOAD: begin
            load_d[lane_q] = 1'b1;
            tap_d[lane_q]  = '0;
            cnt_d          = '0;
            state_d        = S_SETTLE;
         end
         S_SETTLE: begin
            if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == CW'(SETTLE_CYC - 1)) state_d = S_MOVE;
            else cnt_d = cnt_q + CW'(1);
         end
         S_MOVE: begin
            if (bad_q || tap_q[lane_q] == tgt_q) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               move_d[lane_q] = 1'b1;
               dir_d[lane_q]  = tgt_q > tap_q[lane_q];
               tap_d[lane_q]  = (tgt_q > tap_q[lane_q]) ? tap_q[lane_q] + TAP_W'(1) : tap_q[lane_q] - TAP_W'(1);
               cnt_d          = '0;
               state_d        = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      rdy_d = state_d == S_IDLE;
      cur_d = bad_q ? cur_q : tap_q[lane_q];
   end

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
         tgt_q   <= '0;
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
         move_q  <= '0;
         load_q  <= '0;
         dir_q   <= '0;
         cnt_q   <= '0;
         cur_q   <= '0;
         tap_q   <= '{default: '0};
         tx_q    <= '{default: '0};
         oe_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         tgt_q   <= tgt_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
         move_q  <= move_d;
         load_q  <= load_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         tap_q   <= tap_d;
         tx_q    <= tx_d;
         oe_q    <= oe_d;
      end
   end

   assign TX_DATA              = tx_q[PIPE-1];
   assign OE_DATA              = oe_q[PIPE-1];
   assign DL_REQ_READY         = rdy_q;
   assign DELAY_LINE_MOVE      = move_q;
   assign DELAY_LINE_DIRECTION = dir_q;
   assign DELAY_LINE_LOAD      = load_q;
   assign DL_DONE              = done_q;
   assign DL_ERR               = err_q;
   assign DL_CUR_TAP           = cur_q;
endmodule

// File: tb/tb_ddr3_ca_lane_ctrl.sv
// tb_ddr3_ca_lane_ctrl: directed checks of data path, tap controller timing, errors and reset.
module tb_ddr3_ca_lane_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [59:0] ca_data, tx_data, oe_data;
   logic [3:0]  ca_oe;
   logic        req_valid, req_ready, req_load, dl_done, dl_err;
   logic [3:0]  req_lane;
   logic [7:0]  req_tap, cur_tap;
   logic [14:0] dl_move, dl_dir, dl_load, oor, oor_hit, oor_bg;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, last_p = -100, mv_tot = 0, ld_tot = 0, dir1_tot = 0, gap4_tot = 0;
   int other_tot = 0, multi_tot = 0, done_tot = 0, fire_at = 0, exp_lane = 0;

   assign oor = oor_hit | oor_bg;

   ddr3_ca_lane_ctrl dut (
      .FAB_CLK(clk), .TX_SYNC_RST(rst), .CA_DATA(ca_data), .CA_OE(ca_oe),
      .TX_DATA(tx_data), .OE_DATA(oe_data), .DL_REQ_VALID(req_valid), .DL_REQ_READY(req_ready),
      .DL_REQ_LANE(req_lane), .DL_REQ_TAP(req_tap), .DL_REQ_LOAD(req_load),
      .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_LOAD(dl_load),
      .DELAY_LINE_OUT_OF_RANGE(oor), .DL_DONE(dl_done), .DL_ERR(dl_err), .DL_CUR_TAP(cur_tap)
   );

   always #5 clk = ~clk;

   initial oor_hit = '0;
   always @(negedge clk) begin
      cyc++;
      if (|(dl_move | dl_load)) begin
         if (cyc - last_p == 4) gap4_tot++;
         last_p = cyc;
         if (|((dl_move | dl_load) & ~(15'(1) << exp_lane))) other_tot++;
      end
      if ($countones(dl_move | dl_load) > 1) multi_tot++;
      if (|dl_load) ld_tot++;
      if (|dl_move) begin
         mv_tot++;
         if (|(dl_move & dl_dir)) dir1_tot++;
         if (fire_at != 0 && mv_tot == fire_at) oor_hit[5] = 1'b1;
      end
      if (dl_done) begin
         done_tot++;
         oor_hit = '0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_req(input int lane, input int tap, input bit ld, output int lat);
      int w = 0;
      exp_lane  = lane;
      req_lane  = lane[3:0];
      req_tap   = tap[7:0];
      req_load  = ld;
      req_valid = 1'b1;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!dl_done && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, mv0, ld0, d10, g0, o0, d0, w;
      logic [59:0] p1, p2, ones, oe5;
      p1 = 60'h5A5F0F03C3CA123;
      p2 = 60'h123456789ABCDEF;
      ones = '1;
      oe5 = {15{4'h5}};
      rst = 1'b1; ca_data = p1; ca_oe = 4'hF; req_valid = 1'b0;
      req_lane = '0; req_tap = '0; req_load = 1'b0; oor_bg = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx_data, 0);
      chk("rst_oe", oe_data, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_ctl", {dl_move, dl_dir, dl_load, dl_done, dl_err, cur_tap}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);
      chk("tx_p1", tx_data, p1);
      chk("tx_lane3", tx_data[15:12], 4'b1010);
      chk("oe_all_ones", oe_data, ones);
      ca_data = p2; ca_oe = 4'h5;
      @(negedge clk);
      chk("tx_p2_pipe1", tx_data, p2);
      chk("oe_5", oe_data, oe5);

      // lane 2: load then three increments, lane 4 range flag must be ignored
      oor_bg = 15'h0010;
      mv0 = mv_tot; ld0 = ld_tot; d10 = dir1_tot; g0 = gap4_tot; o0 = other_tot;
      do_req(2, 3, 1, lat);
      oor_bg = '0;
      chk("l2_load_lat", lat, 18);
      chk("l2_load_pulses", ld_tot - ld0, 1);
      chk("l2_moves", mv_tot - mv0, 3);
      chk("l2_dir_up", dir1_tot - d10, 3);
      chk("l2_spacing", gap4_tot - g0, 3);
      chk("l2_other_lane", other_tot - o0, 0);
      chk("l2_cur", cur_tap, 3);
      chk("l2_err", dl_err, 0);
      chk("l2_dir_held", dl_dir, 15'h0004);
      chk("tx_during_adj", tx_data, p2);

      mv0 = mv_tot; d10 = dir1_tot; g0 = gap4_tot;
      do_req(2, 1, 0, lat);
      chk("l2_down_lat", lat, 10);
      chk("l2_down_moves", mv_tot - mv0, 2);
      chk("l2_down_dir", dir1_tot - d10, 0);
      chk("l2_down_spacing", gap4_tot - g0, 1);
      chk("l2_down_cur", cur_tap, 1);
      chk("l2_dir_cleared", dl_dir, 0);

      mv0 = mv_tot; ld0 = ld_tot;
      do_req(2, 200, 1, lat);
      chk("bad_tap_lat", lat, 2);
      chk("bad_tap_err", dl_err, 1);
      chk("bad_tap_pulses", (mv_tot - mv0) + (ld_tot - ld0), 0);
      chk("bad_tap_cur", cur_tap, 1);
      do_req(15, 3, 0, lat);
      chk("bad_lane_lat", lat, 2);
      chk("bad_lane_err", dl_err, 1);
      chk("bad_lane_pulses", mv_tot - mv0, 0);
      do_req(2, 1, 0, lat);
      chk("zero_step_lat", lat, 2);
      chk("zero_step_err", dl_err, 0);
      chk("zero_step_moves", mv_tot - mv0, 0);
      chk("max_tap_ok_err", dl_err, 0);

      // lane 5: range flag raised on the second move of a five-step request
      mv0 = mv_tot;
      fire_at = mv_tot + 2;
      do_req(5, 5, 0, lat);
      fire_at = 0;
      chk("oor_lat", lat, 7);
      chk("oor_moves", mv_tot - mv0, 2);
      chk("oor_err", dl_err, 1);
      chk("oor_cur", cur_tap, 2);
      chk("multi_pulse", multi_tot, 0);

      // reset while settling aborts the request
      exp_lane = 6; req_lane = 4'd6; req_tap = 8'd5; req_load = 1'b0; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      w = 0;
      while (!(|dl_move) && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("l6_first_move", dl_move, 15'h0040);
      rst = 1'b1;
      d0 = done_tot;
      @(negedge clk);
      chk("mid_rst_ctl", {dl_move, dl_dir, dl_load, dl_done, dl_err, cur_tap, req_ready}, 0);
      chk("mid_rst_tx", tx_data | oe_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_no_done", done_tot - d0, 0);
      mv0 = mv_tot;
      do_req(6, 1, 0, lat);
      chk("post_rst_lat", lat, 6);
      chk("post_rst_moves", mv_tot - mv0, 1);
      chk("post_rst_cur", cur_tap, 1);
      do_req(2, 0, 0, lat);
      chk("post_rst_l2_zero", lat, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ddr3_ca_lane_ctrl.md
DDR3_CA_LANE_CTRL -- requirements
Module: ddr3_ca_lane_ctrl

Interface
REQ-001 Parameter LANES, default 15, number of address/command lanes driven (1..32).
REQ-002 Parameter RATIO, default 4, fabric-to-pad serialisation ratio, bits per lane per FAB_CLK (2 or 4).
REQ-003 Parameter TAP_W, default 8, delay-line tap counter width.
REQ-004 Parameter MAX_TAP, default 127, highest legal tap value (MAX_TAP < 2^TAP_W).
REQ-005 Parameter SETTLE_CYC, default 3, idle cycles after every LOAD/MOVE pulse (>=1).
REQ-006 Parameter PIPE, default 1, data-path register stages (1..3).
REQ-007 FAB_CLK  in  1  sole clock; all logic is rising-edge.
REQ-008 TX_SYNC_RST  in  1  reset, synchronous, active-high.
REQ-009 CA_DATA  in  LANES*RATIO  lane L occupies bits [L*RATIO +: RATIO].
REQ-010 CA_OE  in  RATIO  per-beat output enable, common to all lanes.
REQ-011 TX_DATA  out  LANES*RATIO  to per-lane IOD serialiser.
REQ-012 OE_DATA  out  LANES*RATIO  to per-lane IOD output-enable serialiser.
REQ-013 DL_REQ_VALID  in  1  delay-adjust request.
REQ-014 DL_REQ_READY  out  1  controller idle, request accepted on VALID&READY.
REQ-015 DL_REQ_LANE  in  clog2(LANES) (min 1)  target lane.
REQ-016 DL_REQ_TAP  in  TAP_W  target tap value.
REQ-017 DL_REQ_LOAD  in  1  1 = reset delay line to tap 0 before moving.
REQ-018 DELAY_LINE_MOVE  out  LANES  one-cycle move pulse per lane.
REQ-019 DELAY_LINE_DIRECTION  out  LANES  1 = increment, 0 = decrement.
REQ-020 DELAY_LINE_LOAD  out  LANES  one-cycle load-to-zero pulse per lane.
REQ-021 DELAY_LINE_OUT_OF_RANGE  in  LANES  per-lane IOD range flag.
REQ-022 DL_DONE  out  1  one-cycle pulse at request completion.
REQ-023 DL_ERR  out  1  sticky error, valid with DL_DONE, cleared at next accepted request.
REQ-024 DL_CUR_TAP  out  TAP_W  tracked tap of most recently addressed lane.

Function
REQ-025 Data path: TX_DATA = CA_DATA and OE_DATA[L*RATIO+b] = CA_OE[b] for every lane, delayed exactly PIPE FAB_CLK cycles; unaffected by delay adjustments.
REQ-026 Controller keeps a TAP_W tracked-tap register per lane, all 0 after reset.
REQ-027 FSM states: IDLE, LOAD, SETTLE, MOVE, DONE; DL_REQ_READY = 1 only in IDLE.
REQ-028 IDLE: on VALID&READY, latch lane/tap/load, clear DL_ERR; DL_REQ_TAP > MAX_TAP or DL_REQ_LANE >= LANES -> DONE with DL_ERR=1, no pulses; else LOAD if DL_REQ_LOAD, else MOVE.
REQ-029 LOAD: DELAY_LINE_LOAD[lane]=1 for one cycle, tracked tap := 0, -> SETTLE.
REQ-030 MOVE: if tracked == target -> DONE (no pulse); else DELAY_LINE_MOVE[lane]=1 for one cycle, DIRECTION[lane] = (target > tracked), tracked +/-1, -> SETTLE.
REQ-031 DELAY_LINE_DIRECTION[lane] is set at the MOVE cycle and held until the next MOVE on that lane; reset value 0.
REQ-032 SETTLE: count SETTLE_CYC cycles, then -> MOVE; if DELAY_LINE_OUT_OF_RANGE[lane]=1 on any SETTLE cycle -> DONE with DL_ERR=1 immediately, tracked tap keeps value after last pulse.
REQ-033 DONE: DL_DONE=1 for one cycle, -> IDLE.
REQ-034 Move/load pulses only ever asserted on the latched lane; at most one bit of DELAY_LINE_MOVE|DELAY_LINE_LOAD is high per cycle.
REQ-035 DL_CUR_TAP = tracked tap of latched lane, updated the cycle after each pulse.
REQ-036 Request of N steps, no load, no error: DL_DONE exactly N*(1+SETTLE_CYC)+2 cycles after acceptance; N=0 gives 2 cycles.
REQ-037 OUT_OF_RANGE of non-latched lanes is ignored.

Reset
REQ-038 TX_SYNC_RST=1 at any clock edge: FSM -> IDLE, all tracked taps 0, pipeline registers 0; TX_DATA, OE_DATA, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DL_DONE, DL_ERR, DL_CUR_TAP = 0; DL_REQ_READY = 0 during reset, 1 the cycle after release.
REQ-039 Reset mid-request aborts without DL_DONE; no pulse issued on reset cycle.

Verification
REQ-040 PIPE=1, CA_DATA lane3 = 4'b1010, CA_OE=4'hF -> TX_DATA[15:12]=1010, OE_DATA all ones one cycle later.
REQ-041 Lane 2, LOAD=1, TAP=3, SETTLE_CYC=3 -> one LOAD pulse, three MOVE pulses DIRECTION=1 spaced 4 cycles, DL_CUR_TAP=3, DL_DONE, DL_ERR=0.
REQ-042 Lane 2 at tap 3, request TAP=1 no load -> two MOVE pulses DIRECTION=0, DL_CUR_TAP=1, done 10 cycles after acceptance.
REQ-043 Request TAP=200 (MAX_TAP=127) -> no pulses, DL_DONE with DL_ERR=1 two cycles after acceptance, taps unchanged.
REQ-044 OUT_OF_RANGE[5] raised after second MOVE of a 5-step request on lane 5 -> DL_DONE, DL_ERR=1, DL_CUR_TAP=2.
REQ-045 TX_SYNC_RST asserted during SETTLE -> no DL_DONE, all outputs 0, READY=1 after release, new request accepted.
